stage4_memory: RTL and testbench

- Pipeline stage between execute and writeback.
- Accepts execute beats over an AXI-Stream-style handshake and issues loads/stores to the data SRAM single port. Stores get byte-lane alignment and strobes; loads are issued so read data is valid the cycle the beat reaches writeback.
- Registers the payload into one output slot, holds it under backpressure, and flags misaligned accesses.

---
 rtl/stage4_memory_pkg.sv | 65 ++++++
 rtl/stage4_memory_store_align.sv | 37 +++
 rtl/stage4_memory.sv | 110 +++++++++++
 tb/tb_stage4_memory.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage4_memory_pkg.sv
// Shared types and constants for the memory pipeline stage.
package stage4_memory_pkg;

  localparam int unsigned REGISTER_WIDTH = 32;
  localparam int unsigned ADDRESS_WIDTH  = 32;
  localparam int unsigned BYTE_WIDTH     = 8;
  localparam int unsigned LANES          = REGISTER_WIDTH / BYTE_WIDTH;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd;
  } decoded_instruction_t;

  typedef struct packed {
    decoded_instruction_t        decoded_instruction;
    logic [REGISTER_WIDTH-1:0]   alu_result;
    logic [REGISTER_WIDTH-1:0]   rs2_value;
    logic                        misaligned;
  } pipeline_payload_t;

  typedef enum logic [1:0] {
    SizeByte,
    SizeHalf,
    SizeWord
  } access_size_e;

  // Unknown funct3 encodings fall back to word width.
  function automatic access_size_e load_size(input logic [2:0] funct3);
    unique case (funct3)
      F3_LB, F3_LBU: return SizeByte;
      F3_LH, F3_LHU: return SizeHalf;
      default:       return SizeWord;
    endcase
  endfunction

  function automatic access_size_e store_size(input logic [2:0] funct3);
    unique case (funct3)
      F3_SB:   return SizeByte;
      F3_SH:   return SizeHalf;
      default: return SizeWord;
    endcase
  endfunction

  function automatic logic is_misaligned(input access_size_e size, input logic [1:0] addr_lo);
    unique case (size)
      SizeHalf: return addr_lo[0];
      SizeWord: return addr_lo != 2'b00;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/stage4_memory_store_align.sv
// Store lane alignment: byte strobes, replicated write data and misalignment flag.
module stage4_memory_store_align
  import stage4_memory_pkg::*;
(
  input  logic [2:0]                i_funct3,
  input  logic [1:0]                i_addr_lo,
  input  logic [REGISTER_WIDTH-1:0] i_rs2_value,
  output logic [LANES-1:0]          o_byte_enable,
  output logic [REGISTER_WIDTH-1:0] o_write_data,
  output logic                      o_misaligned
);

  access_size_e w_size;

  // Decode store width and place the source data on every lane it could land on.
  always_comb begin
    w_size        = store_size(i_funct3);
    o_misaligned  = is_misaligned(w_size, i_addr_lo);
    o_byte_enable = '1;
    o_write_data  = i_rs2_value;
    unique case (w_size)
      SizeByte: begin
        o_byte_enable = LANES'(1) << i_addr_lo;
        o_write_data  = {LANES{i_rs2_value[BYTE_WIDTH-1:0]}};
      end
      SizeHalf: begin
        o_byte_enable = LANES'(3) << i_addr_lo;
        o_write_data  = {(LANES / 2){i_rs2_value[2*BYTE_WIDTH-1:0]}};
      end
      default: begin
        o_byte_enable = '1;
        o_write_data  = i_rs2_value;
      end
    endcase
  end

endmodule

// File: rtl/stage4_memory.sv
// Memory pipeline stage: one-slot skid-free register with SRAM load/store issue.
module stage4_memory
  import stage4_memory_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_tvalid,
  output logic                      in_tready,
  input  pipeline_payload_t         in_tdata,
  output logic                      out_tvalid,
  input  logic                      out_tready,
  output pipeline_payload_t         out_tdata,
  output logic [ADDRESS_WIDTH-1:0]  sram_address,
  output logic                      sram_read_enable,
  output logic                      sram_write_enable,
  output logic [LANES-1:0]          sram_byte_enable,
  output logic [REGISTER_WIDTH-1:0] sram_write_data,
  input  logic [REGISTER_WIDTH-1:0] sram_read_data
);

  logic                      r_out_tvalid;
  pipeline_payload_t         r_out_tdata;
  logic                      w_accept;
  logic                      w_in_is_load;
  logic                      w_in_is_store;
  logic                      w_in_misaligned;
  logic                      w_hold_load;
  logic [ADDRESS_WIDTH-1:0]  w_in_address;
  logic [ADDRESS_WIDTH-1:0]  w_held_address;
  pipeline_payload_t         w_in_payload;
  logic [LANES-1:0]          w_st_byte_enable;
  logic [REGISTER_WIDTH-1:0] w_st_write_data;
  logic                      w_st_misaligned;
  logic                      w_unused;

  // Read data goes straight to writeback; the incoming misaligned bit is recomputed here.
  assign w_unused = ^{sram_read_data, in_tdata.misaligned};

  assign w_in_address   = ADDRESS_WIDTH'(in_tdata.alu_result);
  assign w_held_address = ADDRESS_WIDTH'(r_out_tdata.alu_result);
  assign w_in_is_load   = in_tdata.decoded_instruction.opcode == OP_LOAD;
  assign w_in_is_store  = in_tdata.decoded_instruction.opcode == OP_STORE;

  assign in_tready  = !rst && (!r_out_tvalid || out_tready);
  assign w_accept   = in_tvalid && in_tready;
  assign out_tvalid = r_out_tvalid;
  assign out_tdata  = r_out_tdata;

  // A stalled load keeps re-reading so its data is still on the bus when writeback takes it.
  assign w_hold_load = !rst && r_out_tvalid && !out_tready
                       && (r_out_tdata.decoded_instruction.opcode == OP_LOAD)
                       && !r_out_tdata.misaligned;

  stage4_memory_store_align u_store_align (
    .i_funct3      (in_tdata.decoded_instruction.funct3),
    .i_addr_lo     (w_in_address[1:0]),
    .i_rs2_value   (in_tdata.rs2_value),
    .o_byte_enable (w_st_byte_enable),
    .o_write_data  (w_st_write_data),
    .o_misaligned  (w_st_misaligned)
  );

  // Misalignment of the incoming beat and the payload that will be captured.
  always_comb begin
    w_in_misaligned = 1'b0;
    if (w_in_is_load) begin
      w_in_misaligned = is_misaligned(load_size(in_tdata.decoded_instruction.funct3),
                                      w_in_address[1:0]);
    end else if (w_in_is_store) begin
      w_in_misaligned = w_st_misaligned;
    end
    w_in_payload            = in_tdata;
    w_in_payload.misaligned = w_in_misaligned;
  end

  // SRAM request: new access on accept, otherwise replay of a stalled load.
  always_comb begin
    sram_address      = '0;
    sram_read_enable  = 1'b0;
    sram_write_enable = 1'b0;
    sram_byte_enable  = '0;
    sram_write_data   = '0;
    if (w_accept && !w_in_misaligned && w_in_is_load) begin
      sram_read_enable = 1'b1;
      sram_address     = w_in_address;
    end else if (w_accept && !w_in_misaligned && w_in_is_store) begin
      sram_write_enable = 1'b1;
      sram_address      = {w_in_address[ADDRESS_WIDTH-1:2], 2'b00};
      sram_byte_enable  = w_st_byte_enable;
      sram_write_data   = w_st_write_data;
    end else if (w_hold_load) begin
      sram_read_enable = 1'b1;
      sram_address     = w_held_address;
    end
  end

  // Output slot: replace on accept, clear on drain, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_tvalid <= 1'b0;
      r_out_tdata  <= '0;
    end else if (w_accept) begin
      r_out_tvalid <= 1'b1;
      r_out_tdata  <= w_in_payload;
    end else if (out_tready) begin
      r_out_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stage4_memory.sv
// Self-checking bench for stage4_memory: directed cases plus random traffic vs. a queue model.
module tb_stage4_memory;
  import stage4_memory_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_tvalid = 1'b0;
  logic              in_tready;
  pipeline_payload_t in_tdata = '0;
  logic              out_tvalid;
  logic              out_tready = 1'b1;
  pipeline_payload_t out_tdata;
  logic [31:0]       sram_address;
  logic              sram_read_enable;
  logic              sram_write_enable;
  logic [3:0]        sram_byte_enable;
  logic [31:0]       sram_write_data;
  logic [31:0]       sram_read_data = 32'hDEAD_BEEF;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  localparam logic [6:0] OP_ALU = 7'b0110011;

  stage4_memory dut (
    .clk               (clk),
    .rst               (rst),
    .in_tvalid         (in_tvalid),
    .in_tready         (in_tready),
    .in_tdata          (in_tdata),
    .out_tvalid        (out_tvalid),
    .out_tready        (out_tready),
    .out_tdata         (out_tdata),
    .sram_address      (sram_address),
    .sram_read_enable  (sram_read_enable),
    .sram_write_enable (sram_write_enable),
    .sram_byte_enable  (sram_byte_enable),
    .sram_write_data   (sram_write_data),
    .sram_read_data    (sram_read_data)
  );

  always #5 clk = ~clk;

  // SRAM stand-in: an address-derived word one cycle after a read, garbage otherwise.
  always @(posedge clk) begin
    sram_read_data <= sram_read_enable ? (32'h5A5A_0000 ^ sram_address) : 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pipeline_payload_t mk(input logic [6:0] op, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [31:0] a,
                                           input logic [31:0] rs2);
    pipeline_payload_t p;
    p = '0;
    p.decoded_instruction.opcode = op;
    p.decoded_instruction.funct3 = f3;
    p.decoded_instruction.rd     = rd;
    p.alu_result                 = a;
    p.rs2_value                  = rs2;
    return p;
  endfunction

  // Access size in bytes from the opcode/funct3 rules.
  function automatic int m_size(input pipeline_payload_t p);
    int f3;
    f3 = int'(p.decoded_instruction.funct3);
    if (p.decoded_instruction.opcode == OP_LOAD) begin
      if (f3 == 0 || f3 == 4) return 1;
      if (f3 == 1 || f3 == 5) return 2;
      return 4;
    end
    if (f3 == 0) return 1;
    if (f3 == 1) return 2;
    return 4;
  endfunction

  function automatic logic m_is_mem(input pipeline_payload_t p);
    return p.decoded_instruction.opcode == OP_LOAD || p.decoded_instruction.opcode == OP_STORE;
  endfunction

  function automatic logic m_mis(input pipeline_payload_t p);
    if (!m_is_mem(p)) return 1'b0;
    return (p.alu_result % m_size(p)) != 0;
  endfunction

  // Reference model: queue of beats held by the stage.
  pipeline_payload_t q[$];
  pipeline_payload_t m_beat;
  logic              m_valid, m_ready, m_acc, m_re, m_we;
  logic [31:0]       m_addr, m_wd;
  logic [3:0]        m_be;
  int                m_sz, m_tmp;

  always @(negedge clk) begin
    if (chk_en) begin
      m_valid = q.size() != 0;
      m_ready = !rst && (!m_valid || out_tready);
      m_acc   = in_tvalid && m_ready;
      m_re = 1'b0; m_we = 1'b0; m_addr = '0; m_wd = '0; m_be = '0;
      m_beat = in_tdata;
      m_beat.misaligned = m_mis(in_tdata);
      if (m_acc && !m_beat.misaligned && m_beat.decoded_instruction.opcode == OP_LOAD) begin
        m_re   = 1'b1;
        m_addr = in_tdata.alu_result;
      end else if (m_acc && !m_beat.misaligned &&
                   m_beat.decoded_instruction.opcode == OP_STORE) begin
        m_sz   = m_size(in_tdata);
        m_we   = 1'b1;
        m_addr = in_tdata.alu_result - (in_tdata.alu_result % 4);
        m_tmp  = ((1 << m_sz) - 1) << (in_tdata.alu_result % 4);
        m_be   = m_tmp[3:0];
        if (m_sz == 1)      m_wd = {4{in_tdata.rs2_value[7:0]}};
        else if (m_sz == 2) m_wd = {2{in_tdata.rs2_value[15:0]}};
        else                m_wd = in_tdata.rs2_value;
      end else if (!rst && m_valid && !out_tready && !q[0].misaligned &&
                   q[0].decoded_instruction.opcode == OP_LOAD) begin
        m_re   = 1'b1;
        m_addr = q[0].alu_result;
      end
      check("out_tvalid", 128'(out_tvalid), 128'(m_valid));
      check("in_tready", 128'(in_tready), 128'(m_ready));
      if (m_valid) begin
        check("out_tdata", 128'(out_tdata), 128'(q[0]));
        if (q[0].decoded_instruction.opcode == OP_LOAD && !q[0].misaligned)
          check("read_data_aligned", 128'(sram_read_data),
                128'(32'h5A5A_0000 ^ q[0].alu_result));
      end
      check("sram_read_enable", 128'(sram_read_enable), 128'(m_re));
      check("sram_write_enable", 128'(sram_write_enable), 128'(m_we));
      check("sram_address", 128'(sram_address), 128'(m_addr));
      check("sram_byte_enable", 128'(sram_byte_enable), 128'(m_be));
      check("sram_write_data", 128'(sram_write_data), 128'(m_wd));
      // Advance the model across the coming clock edge (inputs are stable until then).
      if (rst) begin
        q.delete();
      end else begin
        if (m_valid && out_tready) void'(q.pop_front());
        if (m_acc) q.push_back(m_beat);
      end
    end
  end

  task automatic drive(input logic v, input pipeline_payload_t p, input logic otr,
                       input logic r);
    @(posedge clk);
    #1;
    in_tvalid  = v;
    in_tdata   = p;
    out_tready = otr;
    rst        = r;
  endtask

  int n_wr, n_rd;
  pipeline_payload_t rp;

  initial begin
    // Reset
    drive(1'b0, '0, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_out_tvalid", 128'(out_tvalid), 128'(0));
    check("rst_out_tdata", 128'(out_tdata), 128'(0));
    check("rst_in_tready", 128'(in_tready), 128'(1));
    check("rst_sram", 128'({sram_read_enable, sram_write_enable, sram_byte_enable}), 128'(0));

    // SB at 0x103
    drive(1'b1, mk(OP_STORE, 3'd0, 5'd9, 32'h103, 32'hAABB_CCDD), 1'b1, 1'b0);
    @(negedge clk);
    check("sb_we", 128'(sram_write_enable), 128'(1));
    check("sb_addr", 128'(sram_address), 128'(32'h100));
    check("sb_be", 128'(sram_byte_enable), 128'(4'b1000));
    check("sb_wd", 128'(sram_write_data), 128'(32'hDDDD_DDDD));
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    check("sb_out", 128'(out_tdata), 128'(mk(OP_STORE, 3'd0, 5'd9, 32'h103, 32'hAABB_CCDD)));
    check("sb_out_valid", 128'(out_tvalid), 128'(1));

    // LW at 0x200
    drive(1'b1, mk(OP_LOAD, 3'd2, 5'd3, 32'h200, 32'h0), 1'b1, 1'b0);
    @(negedge clk);
    check("lw_re", 128'(sram_read_enable), 128'(1));
    check("lw_addr", 128'(sram_address), 128'(32'h200));
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    check("lw_out_valid", 128'(out_tvalid), 128'(1));
    check("lw_rdata", 128'(sram_read_data), 128'(32'h5A5A_0200));

    // LH at 0x201 (misaligned)
    drive(1'b1, mk(OP_LOAD, 3'd1, 5'd7, 32'h201, 32'h0), 1'b1, 1'b0);
    @(negedge clk);
    check("lh_no_strobe", 128'({sram_read_enable, sram_write_enable}), 128'(0));
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    check("lh_mis", 128'(out_tdata.misaligned), 128'(1));
    check("lh_rd", 128'(out_tdata.decoded_instruction.rd), 128'(7));

    // LW stalled three cycles
    drive(1'b1, mk(OP_LOAD, 3'd2, 5'd4, 32'h300, 32'h0), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0);
      @(negedge clk);
      check("stall_in_tready", 128'(in_tready), 128'(0));
      check("stall_re", 128'(sram_read_enable), 128'(1));
      check("stall_addr", 128'(sram_address), 128'(32'h300));
      check("stall_rdata", 128'(sram_read_data), 128'(32'h5A5A_0300));
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    check("stall_drain_valid", 128'(out_tvalid), 128'(1));
    check("stall_drain_rdata", 128'(sram_read_data), 128'(32'h5A5A_0300));
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    check("stall_after_drain", 128'(out_tvalid), 128'(0));

    // Back-to-back ADD, SW, LW, ADD
    n_wr = 0;
    n_rd = 0;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: rp = mk(OP_ALU, 3'd0, 5'd1, 32'h11, 32'h22);
        1: rp = mk(OP_STORE, 3'd2, 5'd2, 32'h500, 32'h1234_5678);
        2: rp = mk(OP_LOAD, 3'd2, 5'd3, 32'h504, 32'h0);
        3: rp = mk(OP_ALU, 3'd0, 5'd4, 32'h33, 32'h44);
        default: rp = '0;
      endcase
      drive(i < 4, rp, 1'b1, 1'b0);
      @(negedge clk);
      n_wr += int'(sram_write_enable);
      n_rd += int'(sram_read_enable);
      if (i > 0) begin
        check("b2b_valid", 128'(out_tvalid), 128'(1));
        check("b2b_order", 128'(out_tdata.decoded_instruction.rd), 128'(i));
      end
    end
    check("b2b_writes", 128'(n_wr), 128'(1));
    check("b2b_reads", 128'(n_rd), 128'(1));

    // Reset with a load held in the slot
    drive(1'b1, mk(OP_LOAD, 3'd2, 5'd5, 32'h400, 32'h0), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    check("rstld_no_strobe", 128'({sram_read_enable, sram_write_enable}), 128'(0));
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check("rstld_valid", 128'(out_tvalid), 128'(0));
    check("rstld_no_strobe2", 128'({sram_read_enable, sram_write_enable}), 128'(0));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [6:0]  op;
      logic [31:0] a;
      case ($urandom_range(0, 2))
        0:       op = OP_LOAD;
        1:       op = OP_STORE;
        default: op = OP_ALU;
      endcase
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      rp = mk(op, 3'($urandom_range(0, 7)), 5'($urandom), a, $urandom);
      rp.misaligned = 1'($urandom);
      drive(($urandom_range(0, 9) < 6), rp, ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 99) == 0));
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
